// File: rtl/fifo_pkt_drain.sv
// fifo_pkt_drain: pops a first-word-fall-through 72-bit packet FIFO, tracks
// packet framing, truncates over-length packets with a forced EOP marker and
// forwards one registered word per cycle on a write/ready interface.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   in_data/in_ctrl      FIFO head word, valid while in_empty=0
//   in_empty             FIFO empty flag
//   in_rd_en             pop strobe (combinational)
//   out_data/out_ctrl    registered forwarded word
//   out_wr               registered one-cycle write strobe
//   out_rdy              downstream can take a word next cycle
//   pkt_count            packets whose EOP was forwarded (truncated included)
//   trunc_count          packets truncated
//   trunc_pulse          one-cycle pulse alongside a truncation EOP
module fifo_pkt_drain #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int MAX_PKT_WORDS = 256,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  trunc_count,
    output logic                  trunc_pulse
);

    localparam int WC_W = $clog2(MAX_PKT_WORDS) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_PKT_WORDS - 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_PKT_WORDS);
    localparam logic [CTRL_WIDTH-1:0] CTRL_TRUNC_EOP = CTRL_WIDTH'(8'h80);

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WC_W-1:0]       wc_q, wc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                  out_wr_q, out_wr_d;
    logic                  trunc_pulse_q, trunc_pulse_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]  trunc_count_q, trunc_count_d;

    logic is_hdr, is_pay, is_eop;
    logic rd_en, fwd, eop_fwd, trunc, drop_end;

    assign is_hdr = (in_ctrl == {CTRL_WIDTH{1'b1}});
    assign is_pay = (in_ctrl == '0);
    assign is_eop = !is_hdr && !is_pay;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_HDR;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR: begin
                if (fwd && is_pay) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (eop_fwd)    state_d = S_HDR;
                else if (trunc) state_d = S_DROP;
            end
            S_DROP: begin
                if (drop_end) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    // Output/decode logic. In DROP the FIFO drains regardless of out_rdy
    // because nothing is forwarded.
    always_comb begin
        rd_en    = 1'b0;
        fwd      = 1'b0;
        eop_fwd  = 1'b0;
        trunc    = 1'b0;
        drop_end = 1'b0;
        case (state_q)
            S_HDR: begin
                rd_en   = !in_empty && out_rdy;
                fwd     = rd_en;
                eop_fwd = rd_en && is_eop;
            end
            S_PAYLOAD: begin
                rd_en   = !in_empty && out_rdy;
                fwd     = rd_en;
                eop_fwd = rd_en && !is_pay;
                trunc   = rd_en && is_pay && (wc_q == WC_LAST);
            end
            S_DROP: begin
                rd_en    = !in_empty;
                drop_end = rd_en && is_eop;
            end
            default: ;
        endcase
    end

    assign in_rd_en = rd_en;

    // Datapath next-state
    always_comb begin
        wc_d = wc_q;
        if (eop_fwd || trunc || drop_end)
            wc_d = '0;
        else if (fwd && (wc_q != WC_MAX))
            wc_d = wc_q + WC_W'(1);

        out_wr_d      = fwd;
        out_data_d    = fwd ? in_data : out_data_q;
        out_ctrl_d    = out_ctrl_q;
        if (fwd) out_ctrl_d = trunc ? CTRL_TRUNC_EOP : in_ctrl;
        trunc_pulse_d = trunc;
        pkt_count_d   = pkt_count_q + CNT_WIDTH'(eop_fwd || trunc);
        trunc_count_d = trunc_count_q + CNT_WIDTH'(trunc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wc_q          <= '0;
            out_wr_q      <= 1'b0;
            out_data_q    <= '0;
            out_ctrl_q    <= '0;
            trunc_pulse_q <= 1'b0;
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
        end else begin
            wc_q          <= wc_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_ctrl_q    <= out_ctrl_d;
            trunc_pulse_q <= trunc_pulse_d;
            pkt_count_q   <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign out_wr      = out_wr_q;
    assign out_data    = out_data_q;
    assign out_ctrl    = out_ctrl_q;
    assign trunc_pulse = trunc_pulse_q;
    assign pkt_count   = pkt_count_q;
    assign trunc_count = trunc_count_q;

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Testbench for fifo_pkt_drain: packet-level reference model feeding a
// scoreboard queue, checked by an independent output monitor.
module tb_fifo_pkt_drain;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_empty;
    logic        in_rd_en;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [31:0] pkt_count;
    logic [31:0] trunc_count;
    logic        trunc_pulse;

    always #5 clk = ~clk;

    fifo_pkt_drain #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8),
        .MAX_PKT_WORDS(MAXW),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .out_wr(out_wr),
        .out_rdy(out_rdy),
        .pkt_count(pkt_count),
        .trunc_count(trunc_count),
        .trunc_pulse(trunc_pulse)
    );

    typedef struct {
        logic [7:0]  c;
        logic [63:0] d;
        int          id;
    } in_t;

    typedef struct {
        logic [7:0]  c;
        logic [63:0] d;
        int          id;
        bit          tr;
        bit          eop;
    } exp_t;

    in_t  inq[$];
    exp_t expq[$];
    exp_t me;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int next_id = 0;
    int pop_cyc[8192];
    bit pop_rdy[8192];
    int mon_pkt = 0, mon_trunc = 0;
    int mdl_pkt = 0, mdl_trunc = 0;
    bit mon_en = 0;
    int rdy_mode = 2;
    int rdy_pct = 100;
    int gap_pct = 0;
    bit hold = 0;
    bit rdy_tog = 0;
    int base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [7:0] c);
        in_t w;
        w.c = c;
        w.d = {$urandom, $urandom};
        w.id = next_id;
        next_id++;
        inq.push_back(w);
    endtask

    // Reference model: a packet of L words forwards min(L, MAXW) words;
    // when L exceeds MAXW the last forwarded word carries ctrl 80.
    task automatic add_packet(input int h, input int p,
                              input logic [7:0] eopc);
        logic [7:0] cs[$];
        int L, nf;
        bit tr;
        in_t w;
        exp_t e;
        repeat (h) cs.push_back(8'hFF);
        repeat (p) cs.push_back(8'h00);
        cs.push_back(eopc);
        L = cs.size();
        tr = (L > MAXW);
        nf = tr ? MAXW : L;
        for (int i = 0; i < L; i++) begin
            w.c = cs[i];
            w.d = {$urandom, $urandom};
            w.id = next_id;
            next_id++;
            inq.push_back(w);
            if (i < nf) begin
                e.c = (tr && i == nf - 1) ? 8'h80 : w.c;
                e.d = w.d;
                e.id = w.id;
                e.tr = tr && (i == nf - 1);
                e.eop = (i == nf - 1);
                expq.push_back(e);
            end
        end
        mdl_pkt++;
        if (tr) mdl_trunc++;
    endtask

    task automatic step();
        @(negedge clk);
        in_empty = hold || (inq.size() == 0) ||
                   ($urandom_range(0, 99) < gap_pct);
        if (!in_empty) begin
            in_ctrl = inq[0].c;
            in_data = inq[0].d;
        end else begin
            in_ctrl = 8'($urandom);
            in_data = {$urandom, $urandom};
        end
        if (rdy_mode == 0) begin
            out_rdy = ($urandom_range(0, 99) < rdy_pct);
        end else if (rdy_mode == 1) begin
            out_rdy = !rdy_tog;
            rdy_tog = !rdy_tog;
        end else begin
            out_rdy = 1'b1;
        end
        #2;
        chk("rd_en_while_empty", 72'(in_rd_en && in_empty), 72'(0));
        if (rdy_mode == 1)
            chk("pop_while_not_rdy", 72'(in_rd_en && !out_rdy), 72'(0));
        if (in_rd_en && !in_empty) begin
            pop_cyc[inq[0].id] = cyc;
            pop_rdy[inq[0].id] = out_rdy;
            void'(inq.pop_front());
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((inq.size() != 0 || expq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 72'(inq.size() != 0 || expq.size() != 0),
            72'(0));
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (out_wr) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_wr", 72'(1), 72'(0));
                end else begin
                    me = expq.pop_front();
                    chk("out_ctrl", 72'(out_ctrl), 72'(me.c));
                    chk("out_data", 72'(out_data), 72'(me.d));
                    chk("trunc_pulse", 72'(trunc_pulse), 72'(me.tr));
                    chk("latency", 72'(cyc), 72'(pop_cyc[me.id] + 1));
                    chk("popped_with_rdy", 72'(pop_rdy[me.id]), 72'(1));
                    if (me.eop) begin
                        mon_pkt++;
                        if (me.tr) mon_trunc++;
                        chk("pkt_count", 72'(pkt_count), 72'(mon_pkt));
                        chk("trunc_count", 72'(trunc_count),
                            72'(mon_trunc));
                    end
                end
            end else begin
                chk("idle_trunc_pulse", 72'(trunc_pulse), 72'(0));
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_empty = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_wr", 72'(out_wr), 72'(0));
        chk("rst_out_data", 72'(out_data), 72'(0));
        chk("rst_out_ctrl", 72'(out_ctrl), 72'(0));
        chk("rst_trunc_pulse", 72'(trunc_pulse), 72'(0));
        chk("rst_pkt_count", 72'(pkt_count), 72'(0));
        chk("rst_trunc_count", 72'(trunc_count), 72'(0));
        chk("rst_in_rd_en", 72'(in_rd_en), 72'(0));
        reset = 1'b0;
        mon_en = 1'b1;

        // 4-word packet at full rate
        rdy_mode = 2;
        gap_pct = 0;
        base = next_id;
        add_packet(1, 2, 8'h08);
        drain(50);
        for (int i = 1; i < 4; i++)
            chk("consecutive_pop",
                72'(pop_cyc[base + i] - pop_cyc[base + i - 1]), 72'(1));
        chk("t1_pkt_count", 72'(pkt_count), 72'(1));
        chk("t1_trunc_count", 72'(trunc_count), 72'(0));

        // Over-length packet: FF + 10x00 + 04
        add_packet(1, 10, 8'h04);
        drain(100);
        chk("t2_pkt_count", 72'(pkt_count), 72'(2));
        chk("t2_trunc_count", 72'(trunc_count), 72'(1));

        // Single-word packet right after the truncation
        add_packet(0, 0, 8'h01);
        drain(50);
        chk("t5_pkt_count", 72'(pkt_count), 72'(3));

        // Back-to-back packets with out_rdy toggling
        rdy_mode = 1;
        rdy_tog = 1'b0;
        add_packet(1, 3, 8'h20);
        add_packet(2, 2, 8'h41);
        drain(100);
        chk("t3_pkt_count", 72'(pkt_count), 72'(5));

        // FIFO empty for 3 cycles mid-payload
        rdy_mode = 2;
        add_packet(1, 4, 8'h02);
        repeat (3) step();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k > 0) chk("hold_out_wr", 72'(out_wr), 72'(0));
        end
        hold = 1'b0;
        drain(50);
        chk("t4_pkt_count", 72'(pkt_count), 72'(6));
        chk("t4_trunc_count", 72'(trunc_count), 72'(1));

        // Randomized traffic
        rdy_mode = 0;
        rdy_pct = 70;
        gap_pct = 25;
        repeat (40)
            add_packet($urandom_range(0, 2), $urandom_range(0, 12),
                       8'($urandom_range(1, 254)));
        drain(5000);
        chk("rand_pkt_count", 72'(pkt_count), 72'(mdl_pkt));
        chk("rand_trunc_count", 72'(trunc_count), 72'(mdl_trunc));

        // Async reset mid-payload, between clock edges
        rdy_mode = 2;
        gap_pct = 0;
        mon_en = 1'b0;
        push_word(8'hFF);
        repeat (5) push_word(8'h00);
        repeat (4) step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_wr", 72'(out_wr), 72'(0));
        chk("arst_out_data", 72'(out_data), 72'(0));
        chk("arst_out_ctrl", 72'(out_ctrl), 72'(0));
        chk("arst_trunc_pulse", 72'(trunc_pulse), 72'(0));
        chk("arst_pkt_count", 72'(pkt_count), 72'(0));
        chk("arst_trunc_count", 72'(trunc_count), 72'(0));
        in_empty = 1'b1;
        inq.delete();
        expq.delete();
        mon_pkt = 0;
        mon_trunc = 0;
        mdl_pkt = 0;
        mdl_trunc = 0;
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        add_packet(1, 2, 8'h10);
        drain(50);
        chk("post_rst_pkt_count", 72'(pkt_count), 72'(1));
        chk("post_rst_trunc_count", 72'(trunc_count), 72'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
